sum_exchange_hub: RTL and testbench
===================================

// Module: sum_exchange_hub
// PURPOSE
//  Single-clock, N-core successor to the two-core partial-sum exchange. Each core pushes
//  signed partial sums into its own FIFO; when every FIFO holds a word, the hub pops one
//  from each, reduces them, and returns one registered result per core over a valid/ready
//  handshake. The result mode is selectable: global total, or total excluding the core's
//  own contribution (generalised "other core's sum").
// PARAMETERS
//  N_CORE   2    number of cores (>=2)
//  BW_PSUM  19   core psum width; sum word width SW = BW_PSUM+4
//  DEPTH    4    per-core FIFO depth (power of 2, >=2)
//  RW       --   derived result width = SW + $clog2(N_CORE)
// PORTS
//  clk        in   1           single clock, all state on posedge
//  reset      in   1           synchronous, active-high
//  sum_out    in   N_CORE*SW   core c partial sum at [c*SW +: SW], signed
//  wr_sum     in   N_CORE      push strobe per core
//  fifo_full  out  N_CORE      FIFO c full (combinational from count)
//  mode       in   1           0 = TOTAL, 1 = EXCL (total minus own)
//  sum_in     out  N_CORE*RW   result for core c at [c*RW +: RW], signed, registered
//  sum_valid  out  1           result registers hold an unconsumed result
//  sum_ready  in   1           consumer accepts result this cycle
//  drop_err   out  N_CORE      sticky: push attempted on full FIFO c
// BEHAVIOUR
//  Reset (sync): all FIFO counts/pointers 0; sum_in 0, sum_valid 0, drop_err 0,
//    fifo_full 0. Reset asserted mid-operation discards all queued and pending data.
//  Push: wr_sum[c] && !fifo_full[c] -> write at wr_ptr, count+1. Push while full ->
//    word dropped, drop_err[c] set; full is evaluated from current count, so a push
//    coinciding with a pop on a full FIFO is still dropped.
//  Pop: fire = (all counts != 0) && (!sum_valid || sum_ready); pops all FIFOs together.
//    A word pushed at edge t is pop-eligible on edge t+1 (no fall-through).
//  Reduce (on fire): sign-extend each head to RW; T = sum of heads;
//    mode 0: sum_in[c] = T for all c; mode 1: sum_in[c] = T - head[c]. No overflow
//    possible at RW. mode sampled at the fire edge only.
//  Output handshake: fire -> sum_valid 1 next cycle. sum_valid && sum_ready && !fire ->
//    sum_valid 0. Accept and fire in the same cycle -> new result loads, valid stays 1
//    (full throughput, one result/cycle). sum_in stable while sum_valid && !sum_ready.
//  Latency: all cores push at edge t, outputs idle -> sum_valid high after edge t+1.
//  Simultaneous push and pop on the same FIFO (not full): count unchanged, both occur.
//  Pointers wrap modulo DEPTH; count range 0..DEPTH.
// STRUCTURE
//  Package sum_hub_pkg: SW/RW width function, mode encodings (MODE_TOTAL, MODE_EXCL),
//    signed sign-extension helper.
//  Sub-module sum_fifo (#SW, DEPTH): sync FIFO with push/pop/full/empty/count,
//    instantiated N_CORE times via generate. Top holds fire logic, adder tree, output
//    regs and drop_err.
// TESTING
//  1 N_CORE=2, mode 0: core0 pushes 100, core1 pushes -30 same edge -> 2 cycles later
//    sum_valid=1, sum_in[0]=sum_in[1]=70.
//  2 N_CORE=4, mode 1: heads 5,-7,20,1 (T=19) -> sum_in = 14,26,-1,18.
//  3 Skew: core0 pushes 3 words, core1 none -> no sum_valid; core1 then pushes 1 word ->
//    exactly one result, FIFO0 count = 2 afterwards.
//  4 Backpressure: sum_ready=0, all cores push DEPTH+2 words -> one result held stable,
//    FIFOs fill, fifo_full=1, extra pushes set drop_err; raise sum_ready -> DEPTH results
//    one per cycle, then idle.
//  5 Limits: all cores push max positive (2^(SW-1)-1) then min negative -> exact totals
//    at RW, no wrap; DEPTH wrap-around order preserved over 3*DEPTH words.
//  6 Reset mid-stream with sum_valid=1 and FIFOs half full -> next cycle all outputs 0,
//    drop_err cleared; stale words never appear after reset.

Source files
------------

// File: rtl/sum_hub_pkg.sv
// Shared widths, mode encodings and sign-extension helper for the partial-sum hub.
package sum_hub_pkg;

    localparam logic MODE_TOTAL = 1'b0;
    localparam logic MODE_EXCL  = 1'b1;

    function automatic int sum_width(input int bw_psum);
        return bw_psum + 4;
    endfunction

    function automatic int res_width(input int sw, input int n_core);
        return sw + $clog2(n_core);
    endfunction

    // Treat bit w-1 of val as the sign and replicate it across 64 bits.
    function automatic logic signed [63:0] sext64(input logic [63:0] val, input int w);
        logic signed [63:0] t;
        t = val << (64 - w);
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/sum_fifo.sv
// Purpose: per-core synchronous FIFO holding partial sums.
// Latency: a word pushed at edge t is visible at dout after edge t (pop-eligible at t+1).
// Backpressure: pushes while full and pops while empty are ignored; full is flagged to the caller.
module sum_fifo
    import sum_hub_pkg::*;
#(
    parameter  int SW    = 23,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [SW-1:0] din,
    output logic [SW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [SW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sum_exchange_hub.sv
// Purpose: pop one partial sum per core when all FIFOs hold data, reduce, return per-core result.
// Latency: all cores push at edge t with outputs idle -> sum_valid high after edge t+1.
// Backpressure: results held while sum_valid && !sum_ready; FIFOs absorb up to DEPTH words, excess dropped with sticky drop_err.
module sum_exchange_hub
    import sum_hub_pkg::*;
#(
    parameter  int N_CORE  = 2,
    parameter  int BW_PSUM = 19,
    parameter  int DEPTH   = 4,
    localparam int SW      = sum_width(BW_PSUM),
    localparam int RW      = res_width(SW, N_CORE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CORE*SW-1:0] sum_out,
    input  logic [N_CORE-1:0]    wr_sum,
    output logic [N_CORE-1:0]    fifo_full,
    input  logic                 mode,
    output logic [N_CORE*RW-1:0] sum_in,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [N_CORE-1:0]    drop_err
);

    logic [SW-1:0]        head  [N_CORE];
    logic signed [RW-1:0] ext   [N_CORE];
    logic signed [RW-1:0] res   [N_CORE];
    logic signed [RW-1:0] total;
    logic [N_CORE-1:0]    full_v;
    logic [N_CORE-1:0]    empty_v;
    logic                 fire;

    for (genvar c = 0; c < N_CORE; c++) begin : g_fifo
        sum_fifo #(
            .SW    (SW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (wr_sum[c]),
            .pop   (fire),
            .din   (sum_out[c*SW +: SW]),
            .dout  (head[c]),
            .full  (full_v[c]),
            .empty (empty_v[c])
        );
    end

    assign fifo_full = full_v;
    assign fire      = (empty_v == '0) && (!sum_valid || sum_ready);

    // RW carries $clog2(N_CORE) guard bits, so neither the total nor total-minus-own can wrap.
    always_comb begin
        total = '0;
        for (int c = 0; c < N_CORE; c++) begin
            ext[c] = RW'(sext64(64'(head[c]), SW));
            total  = total + ext[c];
        end
        for (int c = 0; c < N_CORE; c++) begin
            res[c] = (mode == MODE_TOTAL) ? total : total - ext[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_in    <= '0;
            sum_valid <= 1'b0;
            drop_err  <= '0;
        end else begin
            if (fire) begin
                for (int c = 0; c < N_CORE; c++) begin
                    sum_in[c*RW +: RW] <= res[c];
                end
                sum_valid <= 1'b1;
            end else if (sum_ready) begin
                sum_valid <= 1'b0;
            end
            drop_err <= drop_err | (wr_sum & full_v);
        end
    end

endmodule

// File: tb/tb_sum_exchange_hub.sv
// Directed bench: two-core and four-core hubs driven through totals, exclusion, skew, backpressure, limits and reset.
module tb_sum_exchange_hub;

    localparam int SW  = 23;
    localparam int RW2 = 24;
    localparam int RW4 = 25;
    localparam int D   = 4;
    localparam int MAXV = 4194303;
    localparam int MINV = -4194304;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [2*SW-1:0]  so2;
    logic [1:0]       wr2, full2, de2;
    logic             mode2, sv2, rdy2;
    logic [2*RW2-1:0] si2;

    logic [4*SW-1:0]  so4;
    logic [3:0]       wr4, full4, de4;
    logic             mode4, sv4, rdy4;
    logic [4*RW4-1:0] si4;

    int n_cmp = 0;
    int n_bad = 0;

    sum_exchange_hub #(.N_CORE(2), .BW_PSUM(19), .DEPTH(D)) u_dut2 (
        .clk(clk), .reset(reset), .sum_out(so2), .wr_sum(wr2), .fifo_full(full2),
        .mode(mode2), .sum_in(si2), .sum_valid(sv2), .sum_ready(rdy2), .drop_err(de2)
    );

    sum_exchange_hub #(.N_CORE(4), .BW_PSUM(19), .DEPTH(D)) u_dut4 (
        .clk(clk), .reset(reset), .sum_out(so4), .wr_sum(wr4), .fifo_full(full4),
        .mode(mode4), .sum_in(si4), .sum_valid(sv4), .sum_ready(rdy4), .drop_err(de4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] r2(input int c);
        return $signed(si2[c*RW2 +: RW2]);
    endfunction

    function automatic logic signed [63:0] r4(input int c);
        return $signed(si4[c*RW4 +: RW4]);
    endfunction

    task automatic drv2(input int v0, input int v1);
        so2 = {SW'(v1), SW'(v0)};
    endtask

    task automatic drv4(input int v0, input int v1, input int v2, input int v3);
        so4 = {SW'(v3), SW'(v2), SW'(v1), SW'(v0)};
    endtask

    initial begin
        reset = 1'b1;
        so2 = '0; wr2 = '0; mode2 = 1'b0; rdy2 = 1'b0;
        so4 = '0; wr4 = '0; mode4 = 1'b0; rdy4 = 1'b0;
        tick;
        tick;
        chk("rst_sv2", sv2, 0);
        chk("rst_si2", r2(0), 0);
        chk("rst_full2", full2, 0);
        chk("rst_de2", de2, 0);
        chk("rst_sv4", sv4, 0);
        chk("rst_full4", full4, 0);
        reset = 1'b0;

        // two-core total: 100 + (-30)
        drv2(100, -30); wr2 = 2'b11;
        tick;
        wr2 = 2'b00;
        chk("t1_no_fallthrough", sv2, 0);
        tick;
        chk("t1_sv", sv2, 1);
        chk("t1_sum0", r2(0), 70);
        chk("t1_sum1", r2(1), 70);
        rdy2 = 1'b1;
        tick;
        chk("t1_drain", sv2, 0);

        // skew: core0 queues 1,2,3 while core1 is silent
        for (int k = 1; k <= 3; k++) begin
            drv2(k, 0); wr2 = 2'b01;
            tick;
        end
        wr2 = 2'b00;
        tick;
        chk("t3_skew_idle", sv2, 0);
        drv2(0, 10); wr2 = 2'b10;
        tick;
        wr2 = 2'b00;
        chk("t3_wait", sv2, 0);
        tick;
        chk("t3_sv", sv2, 1);
        chk("t3_sum0", r2(0), 11);
        chk("t3_sum1", r2(1), 11);
        tick;
        chk("t3_single", sv2, 0);
        drv2(0, 20); wr2 = 2'b10;
        tick;
        drv2(0, 30);
        tick;
        chk("t3_next_sv", sv2, 1);
        chk("t3_next", r2(0), 22);
        wr2 = 2'b00;
        tick;
        chk("t3_last", r2(1), 33);
        tick;
        chk("t3_empty", sv2, 0);

        // four-core exclusion: heads 5,-7,20,1
        mode4 = 1'b1; rdy4 = 1'b0;
        drv4(5, -7, 20, 1); wr4 = 4'hF;
        tick;
        wr4 = 4'h0;
        tick;
        chk("t2_sv", sv4, 1);
        chk("t2_c0", r4(0), 14);
        chk("t2_c1", r4(1), 26);
        chk("t2_c2", r4(2), -1);
        chk("t2_c3", r4(3), 18);
        mode4 = 1'b0;
        tick;
        chk("t2_hold_val", r4(0), 14);
        chk("t2_hold_sv", sv4, 1);
        rdy4 = 1'b1;
        tick;
        chk("t2_drain", sv4, 0);

        // backpressure: DEPTH+2 words per core with consumer stalled
        rdy4 = 1'b0;
        for (int k = 1; k <= D + 2; k++) begin
            drv4(10*k, 10*k + 1, 10*k + 2, 10*k + 3); wr4 = 4'hF;
            tick;
            if (k == D + 1) begin
                chk("t4_full", full4, 15);
                chk("t4_no_drop_yet", de4, 0);
            end
        end
        wr4 = 4'h0;
        chk("t4_drop", de4, 15);
        chk("t4_held_sv", sv4, 1);
        chk("t4_held_val", r4(2), 46);
        rdy4 = 1'b1;
        for (int k = 2; k <= D + 1; k++) begin
            tick;
            chk("t4_burst_sv", sv4, 1);
            chk("t4_burst_val", r4(0), 40*k + 6);
        end
        tick;
        chk("t4_idle_sv", sv4, 0);
        chk("t4_idle_full", full4, 0);

        // extremes of the SW-bit input range
        drv4(MAXV, MAXV, MAXV, MAXV); wr4 = 4'hF;
        tick;
        drv4(MINV, MINV, MINV, MINV);
        tick;
        wr4 = 4'h0;
        chk("t5_max", r4(1), 64'sd16777212);
        tick;
        chk("t5_min", r4(3), -64'sd16777216);
        tick;
        chk("t5_idle", sv4, 0);

        // streaming through 3*DEPTH words exercises pointer wrap
        for (int k = 1; k <= 3*D; k++) begin
            drv4(k, 2*k, 3*k, 4*k); wr4 = 4'hF;
            tick;
            if (k > 1) begin
                chk("t5_wrap", r4(0), 10*(k - 1));
            end
        end
        wr4 = 4'h0;
        tick;
        chk("t5_wrap_last", r4(0), 10*3*D);
        tick;
        chk("t5_wrap_idle", sv4, 0);

        // reset with a held result and queued words
        rdy4 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drv4(100 + k, 100 + k, 100 + k, 100 + k); wr4 = 4'hF;
            tick;
        end
        wr4 = 4'h0;
        chk("t6_pre_sv", sv4, 1);
        chk("t6_pre_val", r4(0), 404);
        chk("t6_pre_de", de4, 15);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_sv", sv4, 0);
        for (int c = 0; c < 4; c++) begin
            chk("t6_si", r4(c), 0);
        end
        chk("t6_full", full4, 0);
        chk("t6_de", de4, 0);
        rdy4 = 1'b1;
        drv4(1, 1, 1, 1); wr4 = 4'hF;
        tick;
        wr4 = 4'h0;
        chk("t6_post_wait", sv4, 0);
        tick;
        chk("t6_post_sv", sv4, 1);
        chk("t6_post_val", r4(0), 4);
        tick;
        chk("t6_no_stale", sv4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
